// File: rtl/airi5c_hasti_sram_slave.sv
// rtl/airi5c_hasti_sram_slave.sv - AHB-lite slave bridging to a single-port synchronous SRAM
//
// Purpose: accepts AHB-lite transfers and turns them into single-port SRAM
// accesses. Reads are issued in the address phase, so read data comes back with
// zero wait states. Writes are committed in the data phase, once hwdata is valid.
// A read that arrives while a write is committing has to wait one cycle, because
// there is only one SRAM port.
//
// Ports:
//   clk, nreset            clock (rising edge) and asynchronous active-low reset
//   hsel, haddr, hwrite,   AHB-lite address phase
//   hsize, htrans
//   hwdata                 AHB-lite write data (data phase)
//   hrdata, hready, hresp  AHB-lite response
//   mem_en, mem_we,        SRAM strobe, write strobe, byte lanes, word address
//   mem_be, mem_addr
//   mem_wdata, mem_rdata   SRAM write data and read data (read data lags mem_en by one cycle)

module airi5c_hasti_sram_slave #(
    parameter int MEM_AWIDTH = 12
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [1:0]            htrans,
    input  logic [31:0]           hwdata,
    output logic [31:0]           hrdata,
    output logic                  hready,
    output logic                  hresp,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        STALL,
        ERR1,
        ERR2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    rd_pending;
    logic                    rd_pending_nxt;
    logic [MEM_AWIDTH-1:0]   wr_addr;
    logic [MEM_AWIDTH-1:0]   wr_addr_nxt;
    logic [3:0]              wr_be;
    logic [3:0]              wr_be_nxt;

    logic                    valid;
    logic                    legal;
    logic [3:0]              lanes;
    logic [MEM_AWIDTH-1:0]   word_addr;
    logic                    unused_inputs;

    assign valid         = hsel & htrans[1];
    assign word_addr     = haddr[MEM_AWIDTH+1:2];
    assign unused_inputs = ^{haddr[31:MEM_AWIDTH+2], htrans[0]};

    always_comb begin
        lanes = 4'b0000;
        legal = 1'b0;
        case (hsize)
            3'd0: begin
                lanes = 4'b0001 << haddr[1:0];
                legal = 1'b1;
            end
            3'd1: begin
                lanes = 4'b0011 << {haddr[1], 1'b0};
                legal = ~haddr[0];
            end
            3'd2: begin
                lanes = 4'b1111;
                legal = (haddr[1:0] == 2'b00);
            end
            default: begin
                lanes = 4'b0000;
                legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
            wr_addr    <= '0;
            wr_be      <= 4'b0000;
        end else begin
            state      <= state_nxt;
            rd_pending <= rd_pending_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_be      <= wr_be_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        rd_pending_nxt = 1'b0;
        wr_addr_nxt    = wr_addr;
        wr_be_nxt      = wr_be;
        hready         = 1'b1;
        hresp          = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = word_addr;
        mem_be         = lanes;

        case (state)
            // STALL re-presents the read the master held during the conflict,
            // so it is handled exactly like an ordinary address phase.
            IDLE, STALL: begin
                state_nxt = IDLE;
                if (valid) begin
                    if (!legal) begin
                        state_nxt = ERR1;
                    end else if (hwrite) begin
                        state_nxt   = WDATA;
                        wr_addr_nxt = word_addr;
                        wr_be_nxt   = lanes;
                    end else begin
                        mem_en         = 1'b1;
                        rd_pending_nxt = 1'b1;
                    end
                end
            end
            WDATA: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_be    = wr_be;
                state_nxt = IDLE;
                if (valid) begin
                    if (!legal) begin
                        state_nxt = ERR1;
                    end else if (hwrite) begin
                        state_nxt   = WDATA;
                        wr_addr_nxt = word_addr;
                        wr_be_nxt   = lanes;
                    end else begin
                        // SRAM port busy with the write: hold the read off one cycle.
                        hready    = 1'b0;
                        state_nxt = STALL;
                    end
                end
            end
            ERR1: begin
                hready    = 1'b0;
                hresp     = 1'b1;
                state_nxt = ERR2;
            end
            // Second error cycle: the master cancels whatever it drives here,
            // so nothing is accepted and no SRAM access is made.
            ERR2: begin
                hresp     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The read strobe is combinational from the live bus, so it must be
        // masked while reset is held.
        if (!nreset) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    assign hrdata    = rd_pending ? mem_rdata : 32'h0;
    assign mem_wdata = hwdata;

endmodule

// File: tb/tb_airi5c_hasti_sram_slave.sv
// tb/tb_airi5c_hasti_sram_slave.sv - self-checking bench for airi5c_hasti_sram_slave
module tb_airi5c_hasti_sram_slave;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          nreset;
    logic          hsel;
    logic [31:0]   haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [1:0]    htrans;
    logic [31:0]   hwdata;
    logic [31:0]   hrdata;
    logic          hready;
    logic          hresp;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    airi5c_hasti_sram_slave #(.MEM_AWIDTH(AW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .hsel      (hsel),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] pattern(input int w);
        logic [31:0] wv;
        wv = 32'(w);
        return {16'hC0DE, wv[15:0]};
    endfunction

    // Bench-owned synchronous SRAM.
    logic        sram_init;
    logic [31:0] sram [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= pattern(i);
        end else begin
            if (mem_en && mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a);
        hsel   = sel;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic drive_idle_rand();
        if ($urandom % 2 == 0) drive(1'b0, 2'b10, 1'($urandom % 2), 3'd2, $urandom);
        else                   drive(1'b1, 2'($urandom % 2), 1'($urandom % 2), 3'd2, $urandom);
    endtask

    // ---------------- reference model for the random run ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] data;
    } xfer_t;

    logic [7:0] ref_bytes [0:255];   // byte image of 0x100..0x1FF

    function automatic bit is_legal(input xfer_t x);
        return (x.sz <= 3'd2) && ((x.addr % (32'd1 << x.sz)) == 0);
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        x.wr   = 1'($urandom % 2);
        x.sz   = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
        x.addr = 32'h100 + ($urandom % 256);
        if ($urandom % 3 != 0) x.addr = x.addr & ~((32'd1 << x.sz) - 32'd1);
        x.data = $urandom;
        return x;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int w;
        w = int'(a - 32'h100) & ~3;
        return {ref_bytes[w+3], ref_bytes[w+2], ref_bytes[w+1], ref_bytes[w]};
    endfunction

    task automatic ref_write(input xfer_t x);
        for (int k = 0; k < (1 << x.sz); k++) begin
            int a;
            a = int'(x.addr - 32'h100) + k;
            ref_bytes[a] = x.data[8*(a%4) +: 8];
        end
    endtask

    task automatic run_random(input int n);
        xfer_t       cur;
        xfer_t       dp;
        bit          dp_v;
        bit          have_cur;
        bit          drv;
        bit          err1_seen;
        int          left;
        int          guard;
        logic        r;
        logic        e;
        logic [31:0] d;
        for (int j = 0; j < 256; j++) begin
            logic [31:0] p;
            p = pattern((256 + j) / 4);
            ref_bytes[j] = p[8*(j%4) +: 8];
        end
        dp        = '{default: '0};
        dp_v      = 0;
        err1_seen = 0;
        left      = n - 1;
        cur       = rand_xfer();
        have_cur  = 1;
        drv       = 1;
        guard     = 0;
        next_cycle();
        drive(1'b1, 2'b10, cur.wr, cur.sz, cur.addr);
        while ((left > 0 || have_cur || dp_v) && guard < 20000) begin
            @(negedge clk);
            guard++;
            r = hready;
            e = hresp;
            d = hrdata;
            if (dp_v && !is_legal(dp)) begin
                if (!err1_seen) begin
                    chk("rnd err1 hready", 32'(r), 32'd0);
                    chk("rnd err1 hresp", 32'(e), 32'd1);
                    err1_seen = 1;
                end else begin
                    chk("rnd err2 hready", 32'(r), 32'd1);
                    chk("rnd err2 hresp", 32'(e), 32'd1);
                end
            end else if (dp_v) begin
                chk("rnd hresp", 32'(e), 32'd0);
                if (!dp.wr) begin
                    chk("rnd rd hready", 32'(r), 32'd1);
                    chk("rnd hrdata", d, ref_word(dp.addr));
                end else if (r) begin
                    ref_write(dp);
                end
            end else begin
                chk("rnd idle hready", 32'(r), 32'd1);
                chk("rnd idle hresp", 32'(e), 32'd0);
                chk("rnd idle hrdata", d, 32'd0);
            end
            next_cycle();
            if (r) begin
                dp_v      = drv;
                err1_seen = 0;
                if (drv) begin
                    dp       = cur;
                    have_cur = 0;
                end
                if (dp_v && dp.wr) hwdata = dp.data;
                else               hwdata = $urandom;
                if (!have_cur && left > 0) begin
                    cur      = rand_xfer();
                    have_cur = 1;
                    left--;
                end
                drv = have_cur && ($urandom % 4 != 0);
            end else if (dp_v && !is_legal(dp)) begin
                drv = 0;   // master cancels its next transfer on an error response
            end
            if (drv) drive(1'b1, 2'b10, cur.wr, cur.sz, cur.addr);
            else     drive_idle_rand();
        end
        chk("rnd completed in budget", 32'(guard < 20000), 32'd1);
    endtask

    // ---------------- single-transfer vector table ----------------
    typedef struct {
        logic          sel;
        logic [1:0]    tr;
        logic          wr;
        logic [2:0]    sz;
        logic [31:0]   addr;
        logic          en_a;   // read strobe in the address phase
        logic [3:0]    be;
        logic [AW-1:0] maddr;
        logic          err;
        logic          dwr;    // write strobe in the data phase
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 1'b1, 4'hF, 12'd4, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 3'd0, 32'h13, 1'b1, 4'h8, 12'd4, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 3'd1, 32'h02, 1'b1, 4'hC, 12'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 3'd1, 32'h01, 1'b0, 4'h0, 12'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 3'd2, 32'h06, 1'b0, 4'h0, 12'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 3'd3, 32'h00, 1'b0, 4'h0, 12'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 2'b10, 1'b1, 3'd0, 32'h13, 1'b0, 4'h8, 12'd4, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 2'b10, 1'b1, 3'd1, 32'h22, 1'b0, 4'hC, 12'd8, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 3'd2, 32'h10, 1'b0, 4'h0, 12'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 3'd2, 32'h10, 1'b0, 4'h0, 12'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 1'b0, 4'hF, 12'd8, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 2'b10, 1'b1, 3'd0, 32'h01, 1'b0, 4'h2, 12'd0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 2'b10, 1'b1, 3'd1, 32'h03, 1'b0, 4'h0, 12'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 2'b11, 1'b0, 3'd0, 32'h05, 1'b1, 4'h2, 12'd1, 1'b0, 1'b0};

        // ---- reset state, with a valid read driven on the bus ----
        sram_init = 1'b1;
        nreset    = 1'b0;
        hwdata    = 32'h0;
        drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        chk("reset hready", 32'(hready), 32'd1);
        chk("reset hresp", 32'(hresp), 32'd0);
        chk("reset hrdata", hrdata, 32'd0);
        chk("reset mem_en", 32'(mem_en), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        sram_init = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
        nreset = 1'b1;

        // ---- table-driven single transfers from IDLE ----
        foreach (vecs[i]) begin
            automatic vec_t v = vecs[i];
            next_cycle();
            drive(v.sel, v.tr, v.wr, v.sz, v.addr);
            @(negedge clk);
            chk("vec addr-phase mem_en", 32'(mem_en), 32'(v.en_a));
            chk("vec addr-phase hready", 32'(hready), 32'd1);
            chk("vec addr-phase hresp", 32'(hresp), 32'd0);
            if (v.en_a) begin
                chk("vec rd mem_we", 32'(mem_we), 32'd0);
                chk("vec rd mem_be", 32'(mem_be), 32'(v.be));
                chk("vec rd mem_addr", 32'(mem_addr), 32'(v.maddr));
            end
            next_cycle();
            drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
            hwdata = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            chk("vec data-phase hresp", 32'(hresp), 32'(v.err));
            chk("vec data-phase hready", 32'(hready), 32'(!v.err));
            chk("vec data-phase mem_en", 32'(mem_en), 32'(v.dwr));
            chk("vec data-phase mem_we", 32'(mem_we), 32'(v.dwr));
            if (v.dwr) begin
                chk("vec wr mem_be", 32'(mem_be), 32'(v.be));
                chk("vec wr mem_addr", 32'(mem_addr), 32'(v.maddr));
                chk("vec wr mem_wdata", mem_wdata, 32'hA000_0000 + 32'(i));
            end
            if (v.en_a) chk("vec rd hrdata", hrdata, pattern(int'(v.maddr)));
            else        chk("vec hrdata idle", hrdata, 32'd0);
            next_cycle();
            @(negedge clk);
            if (v.err) begin
                chk("vec err2 hready", 32'(hready), 32'd1);
                chk("vec err2 hresp", 32'(hresp), 32'd1);
                chk("vec err2 mem_en", 32'(mem_en), 32'd0);
            end
        end

        // ---- word write then read of the same word: one stall cycle ----
        next_cycle();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 32'h10);
        next_cycle();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h10);
        hwdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr-rd WDATA mem_we", 32'(mem_we), 32'd1);
        chk("wr-rd WDATA mem_addr", 32'(mem_addr), 32'd4);
        chk("wr-rd WDATA mem_be", 32'(mem_be), 32'hF);
        chk("wr-rd WDATA hready", 32'(hready), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("wr-rd STALL hready", 32'(hready), 32'd1);
        chk("wr-rd STALL mem_en", 32'(mem_en), 32'd1);
        chk("wr-rd STALL mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        chk("wr-rd hrdata", hrdata, 32'hDEADBEEF);
        chk("wr-rd data hready", 32'(hready), 32'd1);

        // ---- back-to-back reads ----
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k < 3) drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h40 + 32'(4*k));
            else       drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
            @(negedge clk);
            chk("b2b hready", 32'(hready), 32'd1);
            if (k < 3) chk("b2b mem_addr", 32'(mem_addr), 32'(16 + k));
            if (k > 0) chk("b2b hrdata", hrdata, pattern(15 + k));
        end

        // ---- two consecutive writes ----
        next_cycle();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 32'h20);
        next_cycle();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 32'h24);
        hwdata = 32'h1111_2222;
        @(negedge clk);
        chk("ww first mem_we", 32'(mem_we), 32'd1);
        chk("ww first mem_addr", 32'(mem_addr), 32'd8);
        chk("ww first hready", 32'(hready), 32'd1);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
        hwdata = 32'h3333_4444;
        @(negedge clk);
        chk("ww second mem_we", 32'(mem_we), 32'd1);
        chk("ww second mem_addr", 32'(mem_addr), 32'd9);
        chk("ww second mem_wdata", mem_wdata, 32'h3333_4444);
        chk("ww second hready", 32'(hready), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("ww after mem_en", 32'(mem_en), 32'd0);

        // ---- reset pulsed during WDATA ----
        next_cycle();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 32'h30);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
        hwdata = 32'h5555_5555;
        #1;
        chk("rst-wdata pre mem_we", 32'(mem_we), 32'd1);
        nreset = 1'b0;
        #1;
        chk("rst-wdata hready", 32'(hready), 32'd1);
        chk("rst-wdata hresp", 32'(hresp), 32'd0);
        chk("rst-wdata hrdata", hrdata, 32'd0);
        chk("rst-wdata mem_en", 32'(mem_en), 32'd0);
        chk("rst-wdata mem_we", 32'(mem_we), 32'd0);
        drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h44);
        #1;
        chk("rst-wdata read masked", 32'(mem_en), 32'd0);
        next_cycle();
        nreset = 1'b1;
        #1;
        chk("post-rst rd mem_en", 32'(mem_en), 32'd1);
        chk("post-rst rd mem_addr", 32'(mem_addr), 32'd17);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        chk("post-rst hrdata", hrdata, pattern(17));
        chk("post-rst hready", 32'(hready), 32'd1);
        chk("discarded write", sram[12], pattern(12));

        // ---- randomized traffic against the reference model ----
        run_random(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/airi5c_hasti_sram_slave.md
AIRI5C_HASTI_SRAM_SLAVE -- requirements
Module: airi5c_hasti_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AWIDTH, default 12, SRAM word-address width (memory = 2^MEM_AWIDTH 32-bit words).
REQ-002 SHALL have port clk  input  1  single clock for all state; rising edge.
REQ-003 SHALL have port nreset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port hsel  input  1  slave select.
REQ-005 SHALL have port haddr  input  32  AHB-lite address.
REQ-006 SHALL have port hwrite  input  1  1 = write transfer.
REQ-007 SHALL have port hsize  input  3  transfer size (0 = byte, 1 = half, 2 = word).
REQ-008 SHALL have port htrans  input  2  transfer type; bit 1 set = NONSEQ/SEQ (valid).
REQ-009 SHALL have port hwdata  input  32  write data, valid in the data phase.
REQ-010 SHALL have port hrdata  output  32  read data.
REQ-011 SHALL have port hready  output  1  transfer done / accept.
REQ-012 SHALL have port hresp  output  1  0 = OKAY, 1 = ERROR.
REQ-013 SHALL have ports mem_en, mem_we  output  1 each  SRAM access strobe and write strobe.
REQ-014 SHALL have port mem_be  output  4  SRAM byte-lane enables.
REQ-015 SHALL have port mem_addr  output  MEM_AWIDTH  SRAM word address = haddr[MEM_AWIDTH+1:2].
REQ-016 SHALL have port mem_wdata  output  32  SRAM write data.
REQ-017 SHALL have port mem_rdata  input  32  SRAM read data, valid one cycle after a read strobe.

Function
REQ-018 A transfer SHALL be accepted when hsel & htrans[1] & hready are all 1 at a rising clk edge.
REQ-019 States SHALL be IDLE, WDATA, STALL, ERR1, ERR2; reset state is IDLE.
REQ-020 Byte lanes SHALL be: size 0 -> 4'b0001 << haddr[1:0]; size 1 -> 4'b0011 << {haddr[1],1'b0}; size 2 -> 4'b1111.
REQ-021 A transfer SHALL be illegal if hsize > 2, if hsize = 1 with haddr[0] = 1, or if hsize = 2 with haddr[1:0] != 0.
REQ-022 An illegal transfer SHALL cause no SRAM access and SHALL go to ERR1 (hready = 0, hresp = 1), then ERR2 (hready = 1, hresp = 1), then IDLE.
REQ-023 A legal read SHALL drive mem_en = 1 and mem_we = 0 combinationally in its address-phase cycle, using the live haddr and byte lanes.
REQ-024 In the cycle after a legal read, hrdata SHALL equal mem_rdata with hready = 1 (zero wait states). A registered rd_pending flag selects this.
REQ-025 When no read data phase is active, hrdata SHALL be 32'h0.
REQ-026 A legal write SHALL latch word address and byte lanes at acceptance and go to WDATA.
REQ-027 In WDATA, the block SHALL drive mem_en = 1, mem_we = 1, the latched address and lanes, and mem_wdata = hwdata.
REQ-028 In WDATA, if no new valid transfer is present, or the new one is a write, hready SHALL be 1.
- A new write SHALL be latched and the state SHALL stay WDATA.
- Otherwise the state SHALL return to IDLE.
REQ-029 In WDATA with a new valid read address phase (SRAM port conflict), hready SHALL be 0 and the state SHALL go to STALL.
REQ-030 In STALL, hready SHALL be 1 and the held read SHALL be issued to SRAM (REQ-023). Its data SHALL be returned next cycle per REQ-024.
REQ-031 A new transfer in STALL SHALL be accepted exactly as in IDLE.
REQ-032 An illegal transfer arriving in WDATA SHALL still commit the pending write in that cycle, then enter ERR1.
REQ-033 mem_en SHALL be 0 in ERR1, ERR2, and IDLE without a valid read. hresp SHALL be 0 outside ERR1/ERR2.
REQ-034 Transfers with hsel = 0 or htrans[1] = 0 SHALL be ignored and SHALL always receive hready = 1, hresp = 0.

Reset
REQ-035 While nreset = 0: state = IDLE, rd_pending = 0, latched address/lanes = 0; hready = 1, hresp = 0, hrdata = 0; mem_en = 0, mem_we = 0.
REQ-036 Reset asserted during WDATA or STALL SHALL discard the pending write/read. No SRAM strobe SHALL occur after reset until a new accepted transfer.

Verification
REQ-037 Word write 0x0000_0010 <- 0xDEADBEEF, then read 0x10 -> WDATA: mem_we = 1, mem_addr = 4, mem_be = 4'hF; read: hready low one cycle (STALL), then hrdata = 0xDEADBEEF.
REQ-038 Byte write 0x13 <- 0x000000AA -> mem_be = 4'b1000, mem_addr = 4, hready stays 1 with no following read.
REQ-039 Back-to-back reads 0x0, 0x4, 0x8 -> one read per cycle, hready = 1 throughout, hrdata follows mem_rdata with 1-cycle lag.
REQ-040 Halfword read at 0x1 -> ERR1 (hready = 0, hresp = 1), ERR2 (hready = 1, hresp = 1), no mem_en, then IDLE.
REQ-041 Two consecutive writes 0x20 and 0x24 -> two WDATA cycles with addresses 8 and 9, hready = 1 both cycles, no STALL.
REQ-042 nreset pulsed low during WDATA -> all outputs at REQ-035 values immediately; the next legal read completes normally.
